// File: rtl/idex_alu_ctrl_pipe.sv
// ID/EX ALU-control stage: decodes the ID/EX instruction into a registered ALU opcode
// and sequences multi-cycle mult/div. Optional OVF_CHECK_EN enables signed-overflow flagging.
module idex_alu_ctrl_pipe #(
  parameter int unsigned IDEX_W    = 160,
  parameter int unsigned INSTR_LSB = 0,
  parameter int unsigned MULT_LAT  = 4,
  parameter int unsigned DIV_LAT   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDEX_W-1:0] idex_reg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [4:0]        alu_opr,
  output logic              ovf_check,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic              stall_req
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             start_next;
  logic [1:0]       op_next;

  logic [5:0] op, funct;
  logic [4:0] rt;
  logic [4:0] opr_d;
  logic       ovf_d;
  logic       is_md;
  logic       accept;
  logic       unused_bits;

  assign op    = idex_reg[INSTR_LSB+26 +: 6];
  assign rt    = idex_reg[INSTR_LSB+16 +: 5];
  assign funct = idex_reg[INSTR_LSB    +: 6];
  assign unused_bits = ^idex_reg;

  always_comb begin
    opr_d = '0;
    ovf_d = 1'b0;
    is_md = 1'b0;
    if (op == 6'b000000) begin
      case (funct)
        6'b100000, 6'b100001: opr_d = 5'b00001;
        6'b100010, 6'b100011: opr_d = 5'b00010;
        6'b100100:            opr_d = 5'b00011;
        6'b100101:            opr_d = 5'b00100;
        6'b100110:            opr_d = 5'b00101;
        6'b100111:            opr_d = 5'b00110;
        6'b101010:            opr_d = 5'b00111;
        6'b101011:            opr_d = 5'b01000;
        6'b000000, 6'b000100: opr_d = 5'b01001;
        6'b000010, 6'b000110: opr_d = 5'b01010;
        6'b000011, 6'b000111: opr_d = 5'b01011;
        6'b011000, 6'b011001, 6'b011010, 6'b011011: is_md = 1'b1;
        default:              opr_d = '0;
      endcase
      ovf_d = (funct == 6'b100000) || (funct == 6'b100010);
    end else begin
      case (op)
        6'b001000, 6'b001001: opr_d = 5'b00001;
        6'b001010:            opr_d = 5'b00111;
        6'b001011:            opr_d = 5'b01000;
        6'b001100:            opr_d = 5'b00011;
        6'b001101:            opr_d = 5'b00100;
        6'b001110:            opr_d = 5'b00101;
        6'b001111:            opr_d = 5'b10010;
        6'b100011, 6'b101011, 6'b100000, 6'b100100, 6'b101000: opr_d = 5'b00001;
        6'b000100:            opr_d = 5'b01100;
        6'b000101:            opr_d = 5'b01101;
        6'b000111:            opr_d = 5'b01111;
        6'b000110:            opr_d = 5'b10000;
        6'b000001:            opr_d = (rt == 5'b00001) ? 5'b01110 : 5'b10001;
        default:              opr_d = '0;
      endcase
      ovf_d = (op == 6'b001000);
    end
  end

  assign in_ready  = (state == IDLE) && (!out_valid || ex_ready);
  assign accept    = in_valid && in_ready;
  assign stall_req = in_valid && !in_ready;
  assign md_busy   = (state == MD_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_opr   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_opr   <= opr_d;
    end else if (ex_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OVF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_check <= 1'b0;
    else if (accept) ovf_check <= ovf_d;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
  assign ovf_check  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      md_start <= 1'b0;
      md_op    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      md_start <= start_next;
      md_op    <= op_next;
    end
  end

  // Counter holds remaining busy cycles minus one, so the exit edge lands after exactly LAT cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start_next = 1'b0;
    op_next    = md_op;
    case (state)
      IDLE: begin
        if (accept && is_md) begin
          state_next = MD_BUSY;
          start_next = 1'b1;
          op_next    = funct[1:0];
          cnt_next   = funct[1] ? DIV_CNT : MULT_CNT;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_idex_alu_ctrl_pipe.sv
// Self-checking bench for idex_alu_ctrl_pipe: random and directed stimulus against a
// transaction-level reference model. Honors OVF_CHECK_EN for the overflow expectation.
module tb_idex_alu_ctrl_pipe;

  localparam int unsigned IDEX_W    = 160;
  localparam int unsigned INSTR_LSB = 40;
  localparam int unsigned MULT_LAT  = 4;
  localparam int unsigned DIV_LAT   = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IDEX_W-1:0] idex_reg;
  logic              in_valid;
  logic              in_ready;
  logic              ex_ready;
  logic              out_valid;
  logic [4:0]        alu_opr;
  logic              ovf_check;
  logic              md_start;
  logic [1:0]        md_op;
  logic              md_busy;
  logic              stall_req;

  int cmp_count  = 0;
  int fail_count = 0;

  logic [31:0] cur_instr;
  logic        m_valid;
  logic [4:0]  m_opr;
  logic        m_ovf;
  int          m_left;
  logic        m_start;
  logic [1:0]  m_op;

  always #5 clk = ~clk;

  idex_alu_ctrl_pipe #(
    .IDEX_W(IDEX_W), .INSTR_LSB(INSTR_LSB), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .idex_reg(idex_reg), .in_valid(in_valid),
    .in_ready(in_ready), .ex_ready(ex_ready), .out_valid(out_valid),
    .alu_opr(alu_opr), .ovf_check(ovf_check), .md_start(md_start),
    .md_op(md_op), .md_busy(md_busy), .stall_req(stall_req)
  );

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_opr(input logic [31:0] ins);
    int op, fn, rt;
    op = int'(ins[31:26]); fn = int'(ins[5:0]); rt = int'(ins[20:16]);
    if (op == 0) begin
      case (fn)
        32, 33: return 5'd1;
        34, 35: return 5'd2;
        36: return 5'd3;
        37: return 5'd4;
        38: return 5'd5;
        39: return 5'd6;
        42: return 5'd7;
        43: return 5'd8;
        0, 4: return 5'd9;
        2, 6: return 5'd10;
        3, 7: return 5'd11;
        default: return 5'd0;
      endcase
    end
    case (op)
      8, 9: return 5'd1;
      10: return 5'd7;
      11: return 5'd8;
      12: return 5'd3;
      13: return 5'd4;
      14: return 5'd5;
      15: return 5'd18;
      35, 43, 32, 36, 40: return 5'd1;
      4: return 5'd12;
      5: return 5'd13;
      7: return 5'd15;
      6: return 5'd16;
      1: return (rt == 1) ? 5'd14 : 5'd17;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [31:0] ins);
`ifdef OVF_CHECK_EN
    return (ins[31:26] == 6'd0 && (ins[5:0] == 6'd32 || ins[5:0] == 6'd34)) ||
           ins[31:26] == 6'd8;
`else
    return (ins[31:26] == 6'd63) && 1'b0;
`endif
  endfunction

  function automatic int ref_md_lat(input logic [31:0] ins);
    if (ins[31:26] != 6'd0) return 0;
    if (ins[5:0] == 6'd24 || ins[5:0] == 6'd25) return MULT_LAT;
    if (ins[5:0] == 6'd26 || ins[5:0] == 6'd27) return DIV_LAT;
    return 0;
  endfunction

  function automatic logic exp_ready();
    return (m_left == 0) && (!m_valid || ex_ready);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_opr = '0; m_ovf = 1'b0; m_left = 0; m_start = 1'b0; m_op = '0;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic v, input logic er);
    idex_reg = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    idex_reg[INSTR_LSB +: 32] = ins;
    cur_instr = ins;
    in_valid  = v;
    ex_ready  = er;
  endtask

  task automatic tick();
    logic acc;
    int   lat;
    acc = in_valid && exp_ready();
    @(posedge clk);
    m_start = 1'b0;
    if (m_left > 0) m_left--;
    if (acc) begin
      m_valid = 1'b1;
      m_opr   = ref_opr(cur_instr);
      m_ovf   = ref_ovf(cur_instr);
      lat     = ref_md_lat(cur_instr);
      if (lat > 0) begin
        m_left  = lat;
        m_start = 1'b1;
        m_op    = cur_instr[1:0];
      end
    end else if (ex_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] r_instr(input logic [5:0] fn);
    logic [31:0] r;
    r = $urandom();
    r[31:26] = 6'd0;
    r[5:0] = fn;
    return r;
  endfunction

  function automatic logic [31:0] i_instr(input logic [5:0] op);
    logic [31:0] r;
    r = $urandom();
    r[31:26] = op;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_in(32'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_count++;
    if ({out_valid, alu_opr, ovf_check, md_start, md_op, md_busy} !== 11'd0) begin
      fail_count++;
      $display("FAIL reset_outputs: got %b expected 0", {out_valid, alu_opr, ovf_check, md_start, md_op, md_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_count++;
    if (in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_decode_sweep();
    logic [5:0] fns [16] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                             6'd42, 6'd43, 6'd0, 6'd4, 6'd2, 6'd6, 6'd3, 6'd7};
    logic [5:0] ops [19] = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35,
                             6'd43, 6'd32, 6'd36, 6'd40, 6'd4, 6'd5, 6'd7, 6'd6, 6'd63, 6'd17};
    logic [31:0] ins;
    for (int i = 0; i < 16 + 19 + 2; i++) begin
      if (i < 16) ins = r_instr(fns[i]);
      else if (i < 35) ins = i_instr(ops[i-16]);
      else begin
        ins = i_instr(6'd1);
        ins[20:16] = (i == 35) ? 5'd1 : 5'd0;
      end
      set_in(ins, 1'b1, 1'b1);
      tick();
      cmp_count++;
      if ({out_valid, alu_opr, ovf_check} !== {1'b1, m_opr, m_ovf}) begin
        fail_count++;
        $display("FAIL decode_%08h: got %b expected %b", ins, {out_valid, alu_opr, ovf_check}, {1'b1, m_opr, m_ovf});
      end
      if (i >= 33) begin
        cmp_count++;
        if (alu_opr !== ((i == 35) ? 5'b01110 : (i == 36) ? 5'b10001 : 5'b00000)) begin
          fail_count++;
          $display("FAIL decode_special_%0d: got %b", i, alu_opr);
        end
      end
    end
    set_in(32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    set_in(r_instr(6'd33), 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(r_instr(6'd34), 1'b1, 1'b0);
      #1;
      cmp_count++;
      if ({in_ready, stall_req} !== 2'b01) begin
        fail_count++;
        $display("FAIL bp_stall_%0d: got %b expected 01", k, {in_ready, stall_req});
      end
      tick();
      cmp_count++;
      if ({out_valid, alu_opr} !== {1'b1, 5'b00001}) begin
        fail_count++;
        $display("FAIL bp_hold_%0d: got %b expected 100001", k, {out_valid, alu_opr});
      end
    end
    set_in(r_instr(6'd34), 1'b1, 1'b1);
    #1;
    cmp_count++;
    if ({in_ready, stall_req} !== 2'b10) begin
      fail_count++;
      $display("FAIL bp_release: got %b expected 10", {in_ready, stall_req});
    end
    tick();
    cmp_count++;
    if ({out_valid, alu_opr} !== {1'b1, 5'b00010}) begin
      fail_count++;
      $display("FAIL bp_sub_load: got %b expected 100010", {out_valid, alu_opr});
    end
    set_in(32'd0, 1'b0, 1'b1);
    tick();
    cmp_count++;
    if (out_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL bp_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_mult();
    set_in(32'h0085_0018, 1'b1, 1'b1);
    tick();
    cmp_count++;
    if ({md_start, md_op, md_busy, out_valid, alu_opr} !== {1'b1, 2'b00, 1'b1, 1'b1, 5'b00000}) begin
      fail_count++;
      $display("FAIL mult_start: got %b expected 100110000", {md_start, md_op, md_busy, out_valid, alu_opr});
    end
    for (int k = 1; k <= 4; k++) begin
      set_in(r_instr(6'd32), 1'b1, 1'b1);
      #1;
      cmp_count++;
      if ({in_ready, stall_req} !== 2'b01) begin
        fail_count++;
        $display("FAIL mult_in_ready_%0d: got %b expected 01", k, {in_ready, stall_req});
      end
      tick();
      cmp_count++;
      if ({md_start, md_busy} !== {1'b0, (k < 4)}) begin
        fail_count++;
        $display("FAIL mult_busy_%0d: got %b expected %b", k, {md_start, md_busy}, {1'b0, (k < 4)});
      end
    end
    set_in(r_instr(6'd32), 1'b1, 1'b1);
    #1;
    cmp_count++;
    if (in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL mult_after_ready: got %b expected 1", in_ready);
    end
    tick();
    cmp_count++;
    if ({out_valid, alu_opr} !== {1'b1, 5'b00001}) begin
      fail_count++;
      $display("FAIL mult_next_instr: got %b expected 100001", {out_valid, alu_opr});
    end
  endtask

  task automatic test_divu_lat1();
    set_in(r_instr(6'd27), 1'b1, 1'b1);
    tick();
    cmp_count++;
    if ({md_start, md_op, md_busy} !== 4'b1111) begin
      fail_count++;
      $display("FAIL divu_start: got %b expected 1111", {md_start, md_op, md_busy});
    end
    set_in(32'd0, 1'b0, 1'b1);
    #1;
    cmp_count++;
    if (in_ready !== 1'b0) begin
      fail_count++;
      $display("FAIL divu_in_ready: got %b expected 0", in_ready);
    end
    tick();
    cmp_count++;
    if ({md_start, md_busy, in_ready} !== 3'b001) begin
      fail_count++;
      $display("FAIL divu_done: got %b expected 001", {md_start, md_busy, in_ready});
    end
  endtask

  task automatic test_ovf();
    logic [5:0] sel [3] = '{6'd32, 6'd33, 6'd8};
    logic exp;
    for (int i = 0; i < 3; i++) begin
      set_in((i < 2) ? r_instr(sel[i]) : i_instr(sel[i]), 1'b1, 1'b1);
      tick();
`ifdef OVF_CHECK_EN
      exp = (i != 1);
`else
      exp = 1'b0;
`endif
      cmp_count++;
      if (ovf_check !== exp) begin
        fail_count++;
        $display("FAIL ovf_%0d: got %b expected %b", i, ovf_check, exp);
      end
    end
  endtask

  task automatic test_reset_mid_seq();
    for (int pass = 0; pass < 2; pass++) begin
      set_in(r_instr((pass == 0) ? 6'd26 : 6'd24), 1'b1, 1'b1);
      tick();
      if (pass == 1) begin
        set_in(32'd0, 1'b0, 1'b1);
        tick();
      end
      cmp_count++;
      if (md_busy !== 1'b1) begin
        fail_count++;
        $display("FAIL rst_mid_busy_%0d: got %b expected 1", pass, md_busy);
      end
      set_in(r_instr(6'd32), 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp_count++;
      if ({out_valid, alu_opr, ovf_check, md_start, md_op, md_busy, in_ready} !== 12'b1) begin
        fail_count++;
        $display("FAIL rst_mid_%0d: got %b expected 000000000001",
                 pass, {out_valid, alu_opr, ovf_check, md_start, md_op, md_busy, in_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_in(32'd0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        tick();
        cmp_count++;
        if ({md_start, md_busy, in_ready} !== 3'b001) begin
          fail_count++;
          $display("FAIL rst_after_%0d_%0d: got %b expected 001", pass, k, {md_start, md_busy, in_ready});
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int unsigned s;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      s = $urandom_range(0, 3);
      if (s == 0) ins[31:26] = 6'd0;
      else if (s == 1) begin
        ins[31:26] = 6'd0;
        ins[5:0] = 6'(24 + $urandom_range(0, 3));
      end else if (s == 2) ins[31:26] = 6'($urandom_range(0, 15));
      set_in(ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      #1;
      cmp_count++;
      if ({in_ready, stall_req} !== {exp_ready(), in_valid && !exp_ready()}) begin
        fail_count++;
        $display("FAIL rand_ready_%0d: got %b expected %b", n, {in_ready, stall_req}, {exp_ready(), in_valid && !exp_ready()});
      end
      tick();
      cmp_count++;
      if ({out_valid, alu_opr, ovf_check, md_start, md_op, md_busy} !==
          {m_valid, m_opr, m_ovf, m_start, m_op, (m_left > 0)}) begin
        fail_count++;
        $display("FAIL rand_out_%0d: got %b expected %b", n,
                 {out_valid, alu_opr, ovf_check, md_start, md_op, md_busy},
                 {m_valid, m_opr, m_ovf, m_start, m_op, (m_left > 0)});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode_sweep();
    test_backpressure();
    test_mult();
    test_divu_lat1();
    test_ovf();
    test_reset_mid_seq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
